ws2812_chain_tx: RTL and testbench

//  Serial transmitter for a WS2812 LED chain; the stage directly downstream of dout_wled.

---
 rtl/ws2812_pkg.sv | 45 ++++
 rtl/ws2812_bit_encoder.sv | 115 +++++++++++
 rtl/ws2812_chain_tx.sv | 178 +++++++++++++++++
 tb/tb_ws2812_chain_tx.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ws2812_pkg.sv
// Shared definitions for the WS2812 chain transmitter: pixel layout,
// state encodings and the time-to-cycle conversions used at elaboration.
package ws2812_pkg;

    // Pixel word layout: green is sent first, blue last.
    localparam int WORD_W   = 24;
    localparam int WORD_MSB = 23;
    localparam int G_MSB    = 23;
    localparam int G_LSB    = 16;
    localparam int R_MSB    = 15;
    localparam int R_LSB    = 8;
    localparam int B_MSB    = 7;
    localparam int B_LSB    = 0;
    localparam int BIT_W    = 5;

    // Frame-level sequencing owned by the top.
    typedef enum logic [1:0] {
        FS_LATCH = 2'd0,
        FS_LOAD  = 2'd1,
        FS_SHIFT = 2'd2
    } frame_state_e;

    // Bit-level sequencing owned by the encoder.
    typedef enum logic [1:0] {
        BS_IDLE = 2'd0,
        BS_HIGH = 2'd1,
        BS_LOW  = 2'd2
    } bit_state_e;

    // Nanoseconds to whole clock cycles, truncating.
    function automatic int ns_to_cycles(input int ns, input int clk_mhz);
        return (ns * clk_mhz) / 1000;
    endfunction

    // Microseconds to whole clock cycles.
    function automatic int us_to_cycles(input int us, input int clk_mhz);
        return us * clk_mhz;
    endfunction

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int width_for(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ws2812_bit_encoder.sv
// Shifts one 24-bit word out MSB first as WS2812 pulses. A start strobe
// loads the word; o_word_done marks the final cycle of the last bit.
module ws2812_bit_encoder
    import ws2812_pkg::*;
#(
    parameter int C_T0H  = 9,
    parameter int C_T1H  = 18,
    parameter int C_TBIT = 33
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic [WORD_W-1:0] i_word,
    output logic              o_data,
    output logic              o_word_done
);

    localparam int TCNT_W = width_for(C_TBIT);

    bit_state_e        r_state;
    bit_state_e        w_state_nxt;
    logic [TCNT_W-1:0] r_tcnt;
    logic [WORD_W-1:0] r_shift;
    logic [BIT_W-1:0]  r_bit;
    logic              r_data;
    logic              w_high_end;
    logic              w_bit_end;
    logic              w_last_bit;

    // Next-state decode for the high/low phases of each bit.
    always_comb begin
        w_state_nxt = r_state;
        o_word_done = 1'b0;
        if (r_shift[WORD_MSB]) begin
            w_high_end = (r_tcnt == TCNT_W'(C_T1H - 1));
        end else begin
            w_high_end = (r_tcnt == TCNT_W'(C_T0H - 1));
        end
        w_bit_end  = (r_tcnt == TCNT_W'(C_TBIT - 1));
        w_last_bit = (r_bit == 5'd0);
        case (r_state)
            BS_IDLE: begin
                if (i_start) begin
                    w_state_nxt = BS_HIGH;
                end else begin
                    w_state_nxt = BS_IDLE;
                end
            end
            BS_HIGH: begin
                if (w_high_end) begin
                    w_state_nxt = BS_LOW;
                end else begin
                    w_state_nxt = BS_HIGH;
                end
            end
            BS_LOW: begin
                if (w_bit_end) begin
                    if (w_last_bit) begin
                        o_word_done = 1'b1;
                        w_state_nxt = BS_IDLE;
                    end else begin
                        w_state_nxt = BS_HIGH;
                    end
                end else begin
                    w_state_nxt = BS_LOW;
                end
            end
            default: begin
                w_state_nxt = BS_IDLE;
            end
        endcase
    end

    // Phase register; the line is registered from the next phase so it is glitch-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= BS_IDLE;
            r_data  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_data  <= (w_state_nxt == BS_HIGH);
        end
    end

    // Bit timer counts from HIGH entry to the end of the bit period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tcnt <= '0;
        end else if ((r_state == BS_IDLE) || ((r_state == BS_LOW) && w_bit_end)) begin
            r_tcnt <= '0;
        end else begin
            r_tcnt <= r_tcnt + TCNT_W'(1);
        end
    end

    // Word shifter and remaining-bit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= 24'd0;
            r_bit   <= 5'd0;
        end else if (i_start && (r_state == BS_IDLE)) begin
            r_shift <= i_word;
            r_bit   <= 5'd23;
        end else if ((r_state == BS_LOW) && w_bit_end && !w_last_bit) begin
            r_shift <= {r_shift[WORD_MSB-1:0], 1'b0};
            r_bit   <= r_bit - 5'd1;
        end else begin
            r_shift <= r_shift;
            r_bit   <= r_bit;
        end
    end

    assign o_data = r_data;

endmodule

// File: rtl/ws2812_chain_tx.sv
// WS2812 chain transmitter: holds the GRB frame buffer and refreshes the
// whole chain continuously, with a latch gap after every frame.
module ws2812_chain_tx
    import ws2812_pkg::*;
#(
    parameter int CLK_MHZ   = 27,
    parameter int NUM_LEDS  = 8,
    parameter int T0H_NS    = 350,
    parameter int T1H_NS    = 700,
    parameter int TBIT_NS   = 1250,
    parameter int TLATCH_US = 60
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [23:0] rgb_data,
    input  logic [7:0]  led_num,
    input  logic        write,
    output logic        data,
    output logic        frame_done,
    output logic        busy
);

    localparam int C_T0H    = ns_to_cycles(T0H_NS, CLK_MHZ);
    localparam int C_T1H    = ns_to_cycles(T1H_NS, CLK_MHZ);
    localparam int C_TBIT   = ns_to_cycles(TBIT_NS, CLK_MHZ);
    localparam int C_LATCH  = us_to_cycles(TLATCH_US, CLK_MHZ);
    localparam int LCNT_W   = width_for(C_LATCH);
    localparam int LED_W    = $clog2(NUM_LEDS) + 1;

    // Reject timing sets the encoder cannot represent.
    generate
        if (!((C_T0H > 0) && (C_T0H < C_T1H) && (C_T1H < C_TBIT))) begin : g_bad_timing
            $error("ws2812_chain_tx: need 0 < T0H < T1H < TBIT in cycles");
        end
        if ((NUM_LEDS < 1) || (NUM_LEDS > 256)) begin : g_bad_leds
            $error("ws2812_chain_tx: NUM_LEDS must be 1..256");
        end
        if (C_LATCH < 1) begin : g_bad_latch
            $error("ws2812_chain_tx: latch gap must be at least one cycle");
        end
    endgenerate

    frame_state_e      r_state;
    frame_state_e      w_state_nxt;
    logic [LCNT_W-1:0] r_lcnt;
    logic [LED_W-1:0]  r_led;
    logic [23:0]       r_buf [NUM_LEDS];
    logic [23:0]       w_load_word;
    logic              w_start;
    logic              w_word_done;
    logic              w_frame_end;
    logic              w_lcnt_end;
    logic              w_last_led;
    logic              w_data;
    logic              r_frame_done;
    logic              r_busy;

    // Frame buffer: in-range writes land on the edge, out-of-range indices are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                r_buf[i] <= 24'd0;
            end
        end else begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                if (write && (led_num == 8'(i))) begin
                    r_buf[i] <= rgb_data;
                end else begin
                    r_buf[i] <= r_buf[i];
                end
            end
        end
    end

    // Select the word for the current LED (sees the pre-write value on a collision).
    always_comb begin
        w_load_word = 24'd0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            if (r_led == LED_W'(i)) begin
                w_load_word = r_buf[i];
            end else begin
                w_load_word = w_load_word;
            end
        end
    end

    // Frame sequencing: latch gap, per-LED load, then hand the word to the encoder.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_frame_end = 1'b0;
        w_lcnt_end  = (r_lcnt == LCNT_W'(C_LATCH - 1));
        w_last_led  = (r_led == LED_W'(NUM_LEDS - 1));
        case (r_state)
            FS_LATCH: begin
                if (w_lcnt_end) begin
                    w_state_nxt = FS_LOAD;
                end else begin
                    w_state_nxt = FS_LATCH;
                end
            end
            FS_LOAD: begin
                w_start     = 1'b1;
                w_state_nxt = FS_SHIFT;
            end
            FS_SHIFT: begin
                if (w_word_done) begin
                    if (w_last_led) begin
                        w_frame_end = 1'b1;
                        w_state_nxt = FS_LATCH;
                    end else begin
                        w_state_nxt = FS_LOAD;
                    end
                end else begin
                    w_state_nxt = FS_SHIFT;
                end
            end
            default: begin
                w_state_nxt = FS_LATCH;
            end
        endcase
    end

    // State register plus registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= FS_LATCH;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_busy       <= (w_state_nxt != FS_LATCH);
            r_frame_done <= w_frame_end;
        end
    end

    // Latch-gap counter runs only while in the gap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lcnt <= '0;
        end else if ((r_state == FS_LATCH) && !w_lcnt_end) begin
            r_lcnt <= r_lcnt + LCNT_W'(1);
        end else begin
            r_lcnt <= '0;
        end
    end

    // LED index: parked at 0 during the gap, advanced after each non-final word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_led <= '0;
        end else if (r_state == FS_LATCH) begin
            r_led <= '0;
        end else if ((r_state == FS_SHIFT) && w_word_done && !w_last_led) begin
            r_led <= r_led + LED_W'(1);
        end else begin
            r_led <= r_led;
        end
    end

    ws2812_bit_encoder #(
        .C_T0H  (C_T0H),
        .C_T1H  (C_T1H),
        .C_TBIT (C_TBIT)
    ) u_encoder (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_start     (w_start),
        .i_word      (w_load_word),
        .o_data      (w_data),
        .o_word_done (w_word_done)
    );

    assign data       = w_data;
    assign frame_done = r_frame_done;
    assign busy       = r_busy;

endmodule

// File: tb/tb_ws2812_chain_tx.sv
// Directed bench for ws2812_chain_tx at 27 MHz with a two-LED chain.
module tb_ws2812_chain_tx;

    localparam int T0H    = 9;
    localparam int T1H    = 18;
    localparam int TBIT   = 33;
    localparam int LATCH  = 1620;
    localparam int PERIOD = 3206;

    logic        clk;
    logic        rst_n;
    logic [23:0] rgb_data;
    logic [7:0]  led_num;
    logic        write;
    logic        data;
    logic        frame_done;
    logic        busy;

    int tests_run;
    int tests_failed;
    int cap_hi [48];
    int cap_lo [48];
    int cyc_cnt;
    int fd_count;
    int fd_last;
    int fd_prev;

    ws2812_chain_tx #(
        .CLK_MHZ   (27),
        .NUM_LEDS  (2),
        .T0H_NS    (350),
        .T1H_NS    (700),
        .TBIT_NS   (1250),
        .TLATCH_US (60)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rgb_data   (rgb_data),
        .led_num    (led_num),
        .write      (write),
        .data       (data),
        .frame_done (frame_done),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Timestamp every frame_done sample.
    always @(negedge clk) begin
        cyc_cnt = cyc_cnt + 1;
        if (frame_done === 1'b1) begin
            fd_count = fd_count + 1;
            fd_prev  = fd_last;
            fd_last  = cyc_cnt;
        end
    end

    // Expected high time of frame bit b (G7 of LED0 first).
    function automatic int exp_hi(input int b, input logic [23:0] w0, input logic [23:0] w1);
        logic [23:0] w;
        w = (b < 24) ? w0 : w1;
        return w[23 - (b % 24)] ? T1H : T0H;
    endfunction

    // Measure one frame's pulse widths; optionally write during bit inj_bit + 33 cycles.
    task automatic capture_frame(input int inj_bit, input logic [7:0] inj_led,
                                 input logic [23:0] inj_rgb, output bit ok);
        int   b;
        int   inj_at;
        logic prev;
        b = -1; inj_at = -1; prev = 1'b0; ok = 1'b0;
        for (int c = 0; c < 6000; c++) begin
            if (data === 1'b1 && prev === 1'b0) begin
                b = b + 1;
                if (b < 48) begin
                    cap_hi[b] = 0;
                    cap_lo[b] = 0;
                end
                if (b == inj_bit) inj_at = c + TBIT;
            end
            if (b > 47) break;
            if (b >= 0) begin
                if (data === 1'b1) cap_hi[b] = cap_hi[b] + 1;
                else               cap_lo[b] = cap_lo[b] + 1;
            end
            write    = (c == inj_at);
            led_num  = inj_led;
            rgb_data = inj_rgb;
            if (b == 47 && cap_lo[47] >= 20) begin
                ok = 1'b1;
                break;
            end
            prev = data;
            @(negedge clk);
        end
        write = 1'b0;
    endtask

    task automatic do_write(input logic [7:0] idx, input logic [23:0] val);
        write = 1'b1; led_num = idx; rgb_data = val;
        @(negedge clk);
        write = 1'b0;
    endtask

    task automatic count_latch_lows(output int n);
        n = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (data === 1'b1) break;
            n = n + 1;
        end
    endtask

    task automatic test_reset();
        int n; int fd0; bit ok; int e;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++; if (data !== 1'b0) begin tests_failed++; $display("FAIL reset_data: got %b, expected 0", data); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b, expected 0", busy); end
        tests_run++; if (frame_done !== 1'b0) begin tests_failed++; $display("FAIL reset_frame_done: got %b, expected 0", frame_done); end
        rst_n = 1'b1;
        count_latch_lows(n);
        tests_run++; if (n !== LATCH) begin tests_failed++; $display("FAIL reset_latch_len: got %0d low cycles, expected %0d", n, LATCH); end
        tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL reset_busy_shift: got %b, expected 1", busy); end
        fd0 = fd_count;
        capture_frame(-1, 8'd0, 24'd0, ok);
        tests_run++; if (ok !== 1'b1) begin tests_failed++; $display("FAIL reset_capture: got ok=%0d, expected 1", ok); end
        else begin
            for (int b = 0; b < 48; b++) begin
                e = exp_hi(b, 24'd0, 24'd0);
                tests_run++; if (cap_hi[b] !== e) begin tests_failed++; $display("FAIL reset_bit%0d_high: got %0d, expected %0d", b, cap_hi[b], e); end
                if (b < 47) begin
                    e = (b == 23) ? TBIT + 1 - e : TBIT - e;
                    tests_run++; if (cap_lo[b] !== e) begin tests_failed++; $display("FAIL reset_bit%0d_low: got %0d, expected %0d", b, cap_lo[b], e); end
                end
            end
        end
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (fd_count != fd0) break;
        end
        repeat (5) @(negedge clk);
        tests_run++; if (fd_count !== fd0 + 1) begin tests_failed++; $display("FAIL frame_done_once: got %0d pulse cycles, expected 1", fd_count - fd0); end
    endtask

    task automatic test_frame_period();
        int c0;
        c0 = fd_count;
        for (int c = 0; c < 8000; c++) begin
            @(negedge clk);
            if (fd_count >= c0 + 2) break;
        end
        tests_run++; if (fd_count < c0 + 2) begin tests_failed++; $display("FAIL period_timeout: got %0d pulses, expected 2", fd_count - c0); end
        else begin
            tests_run++; if (fd_last - fd_prev !== PERIOD) begin tests_failed++; $display("FAIL frame_period: got %0d, expected %0d", fd_last - fd_prev, PERIOD); end
        end
    endtask

    task automatic test_out_of_range();
        bit ok; int e;
        do_write(8'd5, 24'hFFFFFF);
        capture_frame(-1, 8'd0, 24'd0, ok);
        tests_run++; if (ok !== 1'b1) begin tests_failed++; $display("FAIL oor_capture: got ok=%0d, expected 1", ok); end
        else begin
            for (int b = 0; b < 48; b++) begin
                e = exp_hi(b, 24'd0, 24'd0);
                tests_run++; if (cap_hi[b] !== e) begin tests_failed++; $display("FAIL oor_bit%0d_high: got %0d, expected %0d", b, cap_hi[b], e); end
            end
        end
    endtask

    task automatic test_write_led0();
        bit ok; int e;
        do_write(8'd0, 24'hFF0000);
        capture_frame(-1, 8'd0, 24'd0, ok);
        tests_run++; if (ok !== 1'b1) begin tests_failed++; $display("FAIL led0_capture: got ok=%0d, expected 1", ok); end
        else begin
            for (int b = 0; b < 48; b++) begin
                e = exp_hi(b, 24'hFF0000, 24'd0);
                tests_run++; if (cap_hi[b] !== e) begin tests_failed++; $display("FAIL led0_bit%0d_high: got %0d, expected %0d", b, cap_hi[b], e); end
                if (b < 47) begin
                    e = (b == 23) ? TBIT + 1 - e : TBIT - e;
                    tests_run++; if (cap_lo[b] !== e) begin tests_failed++; $display("FAIL led0_bit%0d_low: got %0d, expected %0d", b, cap_lo[b], e); end
                end
            end
        end
    endtask

    task automatic test_load_collision();
        bit ok; int e;
        capture_frame(23, 8'd1, 24'h000001, ok);
        tests_run++; if (ok !== 1'b1) begin tests_failed++; $display("FAIL coll_capture: got ok=%0d, expected 1", ok); end
        else begin
            for (int b = 0; b < 48; b++) begin
                e = exp_hi(b, 24'hFF0000, 24'd0);
                tests_run++; if (cap_hi[b] !== e) begin tests_failed++; $display("FAIL coll_old_bit%0d_high: got %0d, expected %0d", b, cap_hi[b], e); end
            end
        end
        capture_frame(-1, 8'd0, 24'd0, ok);
        tests_run++; if (ok !== 1'b1) begin tests_failed++; $display("FAIL coll_next_capture: got ok=%0d, expected 1", ok); end
        else begin
            for (int b = 0; b < 48; b++) begin
                e = exp_hi(b, 24'hFF0000, 24'h000001);
                tests_run++; if (cap_hi[b] !== e) begin tests_failed++; $display("FAIL coll_new_bit%0d_high: got %0d, expected %0d", b, cap_hi[b], e); end
            end
        end
    endtask

    task automatic test_reset_mid_bit();
        int rises; logic prev; bit found; int n; bit ok; int e;
        rises = 0; found = 1'b0; prev = data;
        for (int c = 0; c < 5000; c++) begin
            @(negedge clk);
            if (data === 1'b1 && prev === 1'b0) begin
                if (rises == 10) begin found = 1'b1; break; end
                rises = rises + 1;
            end
            prev = data;
        end
        tests_run++; if (found !== 1'b1) begin tests_failed++; $display("FAIL midbit_find: got %0d rises, expected bit 10", rises); end
        repeat (3) @(negedge clk);
        tests_run++; if (data !== 1'b1) begin tests_failed++; $display("FAIL midbit_high: got %b, expected 1", data); end
        rst_n = 1'b0;
        #1;
        tests_run++; if (data !== 1'b0) begin tests_failed++; $display("FAIL midbit_data_cut: got %b, expected 0", data); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL midbit_busy: got %b, expected 0", busy); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        count_latch_lows(n);
        tests_run++; if (n !== LATCH) begin tests_failed++; $display("FAIL midbit_latch_len: got %0d, expected %0d", n, LATCH); end
        capture_frame(-1, 8'd0, 24'd0, ok);
        tests_run++; if (ok !== 1'b1) begin tests_failed++; $display("FAIL midbit_capture: got ok=%0d, expected 1", ok); end
        else begin
            for (int b = 0; b < 48; b++) begin
                e = exp_hi(b, 24'd0, 24'd0);
                tests_run++; if (cap_hi[b] !== e) begin tests_failed++; $display("FAIL midbit_cleared_bit%0d_high: got %0d, expected %0d", b, cap_hi[b], e); end
            end
        end
    endtask

    // Global time limit so the run always ends.
    initial begin
        #5ms;
        $display("FAIL timeout: simulation exceeded time limit, tests run %0d", tests_run);
        $fatal(1, "timeout");
    end

    initial begin
        tests_run = 0; tests_failed = 0;
        cyc_cnt = 0; fd_count = 0; fd_last = 0; fd_prev = 0;
        rst_n = 1'b0; write = 1'b0; led_num = 8'd0; rgb_data = 24'd0;
        @(negedge clk);
        test_reset();
        test_frame_period();
        test_out_of_range();
        test_write_led0();
        test_load_collision();
        test_reset_mid_bit();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
